// File: rtl/awg_pkg.sv
// Shared types and default widths for the AWG sweep/DDS control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package awg_pkg;

  localparam int FTW_W_DEF   = 32;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_RSVD   = 2'b11
  } sweep_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } sweep_state_t;

endpackage

// File: rtl/sweep_ctrl.sv
// Frequency-sweep controller: steps the DDS tuning word between a start and stop value on timebase ticks.
// Latency: 1 cycle from an accepted start or a step-event tick to the new ftw/ftw_valid.
// Backpressure: none; tick and start are pulse/level inputs, all outputs are free-running registers.
//
// Ports: clk/rst_n (async active-low), tick (1-second pulse), start/abort requests, mode and
// f_start/f_stop/f_step/dwell sweep config (latched on accepted start); ftw/ftw_valid tuning word
// output, busy while sweeping, done on single-shot completion, cfg_err on a rejected start.
module sweep_ctrl
  import awg_pkg::*;
#(
  parameter int FTW_W   = FTW_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FTW_W-1:0]   f_start,
  input  logic [FTW_W-1:0]   f_stop,
  input  logic [FTW_W-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FTW_W-1:0]   ftw,
  output logic               ftw_valid,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  sweep_state_t       state_q, state_d;
  sweep_mode_t        mode_q, mode_d;
  logic [FTW_W-1:0]   fstart_q, fstart_d;
  logic [FTW_W-1:0]   fstop_q, fstop_d;
  logic [FTW_W-1:0]   fstep_q, fstep_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [FTW_W-1:0]   ftw_q, ftw_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [DWELL_W-1:0] dwell_last;

  // a + b, saturating at lim; the sum is one bit wider so a carry-out also clamps.
  function automatic logic [FTW_W-1:0] add_clamp(input logic [FTW_W-1:0] a,
                                                 input logic [FTW_W-1:0] b,
                                                 input logic [FTW_W-1:0] lim);
    logic [FTW_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) add_clamp = lim;
    else                   add_clamp = sum[FTW_W-1:0];
  endfunction

  // a - b, floored at lim; a borrow (b > a) also floors.
  function automatic logic [FTW_W-1:0] sub_clamp(input logic [FTW_W-1:0] a,
                                                 input logic [FTW_W-1:0] b,
                                                 input logic [FTW_W-1:0] lim);
    logic [FTW_W-1:0] diff;
    diff = a - b;
    if ((b > a) || (diff < lim)) sub_clamp = lim;
    else                         sub_clamp = diff;
  endfunction

  // A dwell of 0 behaves as 1: the step fires when the count reaches dwell_eff-1.
  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_SAW;
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      ftw_q    <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      fstart_q <= fstart_d;
      fstop_q  <= fstop_d;
      fstep_q  <= fstep_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      ftw_q    <= ftw_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    fstart_d = fstart_q;
    fstop_d  = fstop_q;
    fstep_d  = fstep_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    ftw_d    = ftw_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        if ((f_step == '0) || (f_stop < f_start)) begin
          err_d = 1'b1;
        end else begin
          state_d  = ST_UP;
          mode_d   = sweep_mode_t'(mode);
          fstart_d = f_start;
          fstop_d  = f_stop;
          fstep_d  = f_step;
          dwell_d  = dwell;
          cnt_d    = '0;
          ftw_d    = f_start;
          vld_d    = 1'b1;
        end
      end
    end else if (tick) begin
      if (cnt_q != dwell_last) begin
        cnt_d = cnt_q + DWELL_W'(1);
      end else begin
        cnt_d = '0;
        vld_d = 1'b1;
        if (state_q == ST_UP) begin
          if (ftw_q != fstop_q) begin
            ftw_d = add_clamp(ftw_q, fstep_q, fstop_q);
          end else begin
            case (mode_q)
              MODE_SAW: ftw_d = fstart_q;
              MODE_TRI: begin
                state_d = ST_DOWN;
                ftw_d   = sub_clamp(fstop_q, fstep_q, fstart_q);
              end
              default: begin
                // Single-shot completion holds ftw and does not signal a new value.
                state_d = ST_IDLE;
                done_d  = 1'b1;
                vld_d   = 1'b0;
              end
            endcase
          end
        end else begin
          if (ftw_q != fstart_q) begin
            ftw_d = sub_clamp(ftw_q, fstep_q, fstart_q);
          end else begin
            state_d = ST_UP;
            ftw_d   = add_clamp(fstart_q, fstep_q, fstop_q);
          end
        end
      end
    end
  end

  assign ftw       = ftw_q;
  assign ftw_valid = vld_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: directed vector table, hand-written corner sequences,
// and randomized sweeps checked against a leg-list model of the expected tuning-word sequence.
module tb_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [31:0] f_start;
  logic [31:0] f_stop;
  logic [31:0] f_step;
  logic [7:0]  dwell;
  logic [31:0] ftw;
  logic        ftw_valid;
  logic        busy;
  logic        done;
  logic        cfg_err;

  sweep_ctrl #(.FTW_W(32), .DWELL_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .f_start  (f_start),
    .f_stop   (f_stop),
    .f_step   (f_step),
    .dwell    (dwell),
    .ftw      (ftw),
    .ftw_valid(ftw_valid),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] up_q[$];
  logic [31:0] dn_q[$];

  typedef struct packed {
    logic [1:0]       m;
    logic [31:0]      s;
    logic [31:0]      e;
    logic [31:0]      st;
    logic [7:0]       dw;
    logic [3:0]       n;
    logic             ends;
    logic             tws;
    logic [7:0][31:0] ex;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected sequence from the leg structure: an up leg start..stop (clamped),
  // a down leg stop..start (clamped, stop excluded); saw repeats the up leg,
  // triangle alternates down leg and up leg (start excluded), single runs the up leg once.
  function automatic int build_seq(input logic [1:0] m, input logic [31:0] s,
                                   input logic [31:0] e, input logic [31:0] st, input int n);
    longint v;
    up_q.delete();
    dn_q.delete();
    exp_q.delete();
    for (longint k = 0; k < 100000; k++) begin
      v = longint'(s) + k * longint'(st);
      if (v >= longint'(e)) begin up_q.push_back(e); break; end
      up_q.push_back(v[31:0]);
    end
    for (longint k = 1; k < 100000; k++) begin
      v = longint'(e) - k * longint'(st);
      if (v <= longint'(s)) begin dn_q.push_back(s); break; end
      dn_q.push_back(v[31:0]);
    end
    foreach (up_q[i]) exp_q.push_back(up_q[i]);
    while (exp_q.size() < n && m != 2'b01 && m != 2'b11) begin
      if (m == 2'b00) begin
        foreach (up_q[i]) exp_q.push_back(up_q[i]);
      end else begin
        foreach (dn_q[i]) exp_q.push_back(dn_q[i]);
        for (int i = 1; i < up_q.size(); i++) exp_q.push_back(up_q[i]);
      end
    end
    return up_q.size();
  endfunction

  // Starts a sweep, steps it n-1 times and then either expects completion (ends) or aborts.
  task automatic run_sweep(input logic [1:0] m, input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] st, input logic [7:0] dw, input int n,
                           input bit ends, input bit tws);
    logic [31:0] last;
    int dwe;
    mode = m; f_start = s; f_stop = e; f_step = st; dwell = dw;
    start = 1'b1; tick = tws;
    cyc();
    start = 1'b0; tick = 1'b0;
    // Config must be latched: scramble the inputs for the rest of the sweep.
    mode = 2'($urandom); f_start = $urandom; f_stop = $urandom; f_step = $urandom; dwell = 8'($urandom);
    chk("start_ftw", ftw, exp_q[0]);
    chk("start_vld", ftw_valid, 1);
    chk("start_busy", busy, 1);
    last = exp_q[0];
    dwe = (dw == 0) ? 1 : int'(dw);
    for (int i = 1; i <= n; i++) begin
      if (i == n && !ends) break;
      for (int t = 0; t < dwe; t++) begin
        repeat ($urandom_range(0, 1)) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        if (t < dwe - 1) begin
          chk("dwell_vld", ftw_valid, 0);
          chk("dwell_ftw", ftw, last);
        end
      end
      if (i < n) begin
        chk("step_ftw", ftw, exp_q[i]);
        chk("step_vld", ftw_valid, 1);
        chk("step_busy", busy, 1);
        chk("step_done", done, 0);
        last = exp_q[i];
      end else begin
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_vld", ftw_valid, 0);
        chk("end_ftw", ftw, last);
        cyc();
        chk("done_pulse", done, 0);
      end
    end
    if (!ends) begin
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_vld", ftw_valid, 0);
      chk("abort_ftw", ftw, last);
      chk("abort_done", done, 0);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic [31:0] s, input logic [31:0] e,
                              input logic [31:0] st, input logic [7:0] dw, input logic [3:0] n,
                              input logic ends, input logic tws, input logic [7:0][31:0] ex);
    vec_t v;
    v.m = m; v.s = s; v.e = e; v.st = st; v.dw = dw; v.n = n; v.ends = ends; v.tws = tws; v.ex = ex;
    return v;
  endfunction

  initial begin
    int n, ul;
    logic [1:0]  m;
    logic [31:0] s, e, st;
    logic [7:0]  dw;
    longint      el;
    bit          ends;

    // Expected values listed element 7 first, element 0 last.
    vecs[0] = mk(2'b01, 100, 130, 10, 1, 4, 1, 0, {32'd0, 32'd0, 32'd0, 32'd0, 32'd130, 32'd120, 32'd110, 32'd100});
    vecs[1] = mk(2'b00, 0, 25, 10, 3, 6, 0, 0, {32'd0, 32'd0, 32'd10, 32'd0, 32'd25, 32'd20, 32'd10, 32'd0});
    vecs[2] = mk(2'b10, 10, 30, 10, 0, 8, 0, 1, {32'd20, 32'd30, 32'd20, 32'd10, 32'd20, 32'd30, 32'd20, 32'd10});
    vecs[3] = mk(2'b01, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 2, 1, 0,
                 {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0});
    vecs[4] = mk(2'b11, 5, 7, 1, 2, 3, 1, 1, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7, 32'd6, 32'd5});
    vecs[5] = mk(2'b00, 50, 50, 3, 1, 3, 0, 0, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd50, 32'd50, 32'd50});
    vecs[6] = mk(2'b01, 50, 50, 3, 1, 1, 1, 0, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd50});
    vecs[7] = mk(2'b10, 0, 25, 10, 1, 8, 0, 0, {32'd10, 32'd0, 32'd5, 32'd15, 32'd25, 32'd20, 32'd10, 32'd0});

    rst_n = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0;
    mode = 2'b00; f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (2) @(negedge clk);
    chk("rst_ftw", ftw, 0);
    chk("rst_vld", ftw_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    rst_n = 1'b1;
    cyc();

    // Rejected starts: zero step, then stop below start.
    mode = 2'b01; f_start = 10; f_stop = 20; f_step = 0; dwell = 1;
    start = 1'b1; cyc(); start = 1'b0;
    chk("err0_pulse", cfg_err, 1);
    chk("err0_busy", busy, 0);
    chk("err0_ftw", ftw, 0);
    chk("err0_vld", ftw_valid, 0);
    cyc();
    chk("err0_once", cfg_err, 0);
    f_start = 9; f_stop = 5; f_step = 1;
    start = 1'b1; cyc(); start = 1'b0;
    chk("err1_pulse", cfg_err, 1);
    chk("err1_busy", busy, 0);
    cyc();
    chk("err1_once", cfg_err, 0);

    for (int i = 0; i < 8; i++) begin
      exp_q.delete();
      for (int j = 0; j < int'(vecs[i].n); j++) exp_q.push_back(vecs[i].ex[j]);
      run_sweep(vecs[i].m, vecs[i].s, vecs[i].e, vecs[i].st, vecs[i].dw, int'(vecs[i].n),
                vecs[i].ends, vecs[i].tws);
    end

    // Start while busy is ignored; abort wins over a simultaneous step tick.
    mode = 2'b00; f_start = 0; f_stop = 100; f_step = 5; dwell = 1;
    start = 1'b1; cyc(); start = 1'b0;
    chk("pr_start_ftw", ftw, 0);
    f_start = 77; start = 1'b1; cyc(); start = 1'b0;
    chk("pr_restart_ftw", ftw, 0);
    chk("pr_restart_vld", ftw_valid, 0);
    chk("pr_restart_busy", busy, 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("pr_step_ftw", ftw, 5);
    chk("pr_step_vld", ftw_valid, 1);
    tick = 1'b1; abort = 1'b1; cyc(); tick = 1'b0; abort = 1'b0;
    chk("pr_abort_busy", busy, 0);
    chk("pr_abort_vld", ftw_valid, 0);
    chk("pr_abort_ftw", ftw, 5);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("pr_idle_tick_vld", ftw_valid, 0);
    chk("pr_idle_tick_ftw", ftw, 5);

    // Reset mid-sweep clears outputs without waiting for a clock edge.
    f_start = 40; f_stop = 90; f_step = 7; dwell = 1;
    start = 1'b1; cyc(); start = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("rs_pre_ftw", ftw, 47);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_ftw", ftw, 0);
    chk("rs_vld", ftw_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_err", cfg_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Randomized sweeps against the leg-list model.
    for (int trial = 0; trial < 30; trial++) begin
      m  = 2'($urandom);
      s  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 100)) : $urandom;
      el = longint'(s) + longint'($urandom_range(0, 60));
      e  = (el > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : el[31:0];
      st = ($urandom_range(0, 4) == 0) ? ($urandom | 32'h1) : 32'($urandom_range(1, 25));
      dw = 8'($urandom_range(0, 3));
      n  = $urandom_range(1, 10);
      ul = build_seq(m, s, e, st, n);
      ends = 1'b0;
      if (m == 2'b01 || m == 2'b11) begin
        if (ul <= 12) begin n = ul; ends = 1'b1; end
        else n = 12;
      end
      run_sweep(m, s, e, st, dw, n, ends, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Frequency-sweep controller that consumes the one-cycle 1-second tick from the timebase and steps the DDS frequency tuning word (FTW) between a start and stop value. It sits between the timebase and the phase accumulator. Its `ftw` output is the phase-increment source while a sweep runs. It supports sawtooth, single-shot and triangle sweeps, with a programmable dwell of N ticks per step.

## Interface
- `FTW_W`, default 32: width of tuning words and step.
- `DWELL_W`, default 8: width of the dwell count, in ticks per step.
- `clk` input, 1: system clock. All logic is on the rising edge.
- `rst_n` input, 1: **asynchronous, active-low reset.**
- `tick` input, 1: one-cycle pulse from the timebase.
- `start` input, 1: level-sampled request to begin a sweep. Acted on only in IDLE.
- `abort` input, 1: stops the sweep. Highest priority.
- `mode` input, 2: 00 saw (repeat up), 01 single-shot up, 10 triangle, 11 reserved (behaves as 01).
- `f_start` input, FTW_W: first FTW of the sweep.
- `f_stop` input, FTW_W: last FTW of the sweep.
- `f_step` input, FTW_W: increment per step.
- `dwell` input, DWELL_W: ticks per step. A value of 0 is treated as 1.
- `ftw` output, FTW_W: current tuning word.
- `ftw_valid` output, 1: one-cycle pulse in each cycle where `ftw` takes a new value.
- `busy` output, 1: high while in UP or DOWN.
- `done` output, 1: one-cycle pulse when a single-shot sweep completes.
- `cfg_err` output, 1: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, UP, DOWN.
- **Latching:** `mode`, `f_start`, `f_stop`, `f_step` and `dwell` are latched on an accepted start. Later input changes have no effect until the next start.
- **Start from IDLE:**
  - If `f_step==0` or `f_stop<f_start`, the start is rejected: pulse `cfg_err`, stay in IDLE, hold `ftw`.
  - Otherwise go to UP, load `ftw=f_start`, pulse `ftw_valid`, and clear the dwell counter.
- **Dwell counter:** counts ticks while busy. A step event is a cycle with `tick`=1 and count==dwell_eff-1. On a step event the counter returns to 0; on other ticks it increments.
- **Step in UP:**
  - If `ftw==f_stop`, this is end-of-leg.
  - Otherwise `ftw = min(ftw+f_step, f_stop)`. The sum is computed FTW_W+1 wide, so a carry out clamps to `f_stop`; there is no wrap-around.
- **Step in DOWN:**
  - If `ftw==f_start`, this is end-of-leg.
  - Otherwise `ftw = max(ftw-f_step, f_start)`. Subtraction is borrow-aware, so a borrow clamps to `f_start`.
- **End-of-leg in UP:**
  - Mode 00: `ftw=f_start`, stay in UP.
  - Mode 01/11: hold `ftw`, pulse `done`, go to IDLE.
  - Mode 10: go to DOWN and load `ftw = max(f_stop-f_step, f_start)`.
- **End-of-leg in DOWN:** go to UP and load `ftw = min(f_start+f_step, f_stop)`.
- **Degenerate sweep (`f_start==f_stop`):**
  - Mode 01: finishes on the first step event.
  - Mode 00 and mode 10: reload the same value every step; `ftw_valid` still pulses.
- Every step event changes or reloads `ftw` and pulses `ftw_valid`.
- **Priority:** abort > start > tick.
  - `abort` in any state: go to IDLE next cycle, hold `ftw`, no `done`, clear the dwell counter.
  - `start` while busy is ignored.
  - `tick` in the same cycle as an accepted start is ignored.

## Timing
- **Reset values:** `ftw`=0, `ftw_valid`=0, `busy`=0, `done`=0, `cfg_err`=0, state IDLE, dwell counter 0, latched config 0.
- **Start latency:** with `start` sampled high at edge N, `busy`, `ftw=f_start` and `ftw_valid` are visible after edge N.
- **Step latency:** with a step event tick sampled at edge N, the new `ftw` and its `ftw_valid` are visible after edge N (1 cycle).
- **Single-shot completion:** `done` and the drop of `busy` appear in the same cycle. `ftw_valid` does not pulse on completion.
- **Abort:** `busy`=0 one cycle after `abort` is sampled.
- Reset is asserted asynchronously and released synchronously by the upstream reset bridge. Reset mid-sweep returns all outputs to their reset values immediately.
- `ftw` is registered and holds between `ftw_valid` pulses.

## Structure
- Shared package `awg_pkg` holds:
  - `sweep_mode_t` with encodings 00 saw, 01 single, 10 triangle, 11 reserved.
  - `sweep_state_t` for IDLE/UP/DOWN.
  - Default constants for `FTW_W` and `DWELL_W`.
- No sub-module is needed. The clamped add/subtract and the dwell counter are small enough to stay inline in one always block.

## Test plan
- **Single-shot:** mode 01, start=100, stop=130, step=10, dwell=1 → after start `ftw` 100, then 110, 120, 130 on successive ticks. On the next tick `done` pulses and `busy` drops; `ftw` stays 130.
- **Saw with clamp and dwell:** mode 00, start=0, stop=25, step=10, dwell=3 → `ftw` sequence 0, 10, 20, 25, 0, …, with a change every 3rd tick only.
- **Triangle:** mode 10, start=10, stop=30, step=10 → `ftw` sequence 10, 20, 30, 20, 10, 20, 30, …
- **Overflow clamp:** FTW_W=32, start=0xFFFF_FFF0, stop=0xFFFF_FFFF, step=0x20 → second value is 0xFFFF_FFFF with no wrap to a small value.
- **Config error:** start with step=0 → `cfg_err` pulses once, `busy` stays 0. Separately, start with stop=5, start=9 → same response.
- **Priority:** tick and start in the same cycle → `ftw=f_start`, no extra step. Abort and tick together mid-sweep → IDLE with `ftw` held and no `ftw_valid`. `rst_n` low mid-sweep → all outputs 0 immediately.
